// File: rtl/clock_pkg.sv
// Purpose : shared types for the clock/alarm button path (FSM state, increment target, button owner).
// Latency : n/a (types and helpers only).
// Backpressure: n/a; no flow control in this block family.
package clock_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HOLD    = 2'd1,
      REPEAT  = 2'd2,
      LOCKOUT = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      TGT_CLK = 2'd0,
      TGT_AL0 = 2'd1,
      TGT_AL1 = 2'd2
   } target_t;

   typedef enum logic {
      OWN_MIN  = 1'b0,
      OWN_HOUR = 1'b1
   } owner_t;

   // alarm1 select outranks alarm0; with neither selected the clock is the target
   function automatic target_t sel_to_target(input logic sel_al0, input logic sel_al1);
      target_t t;
      if (sel_al1)      t = TGT_AL1;
      else if (sel_al0) t = TGT_AL0;
      else              t = TGT_CLK;
      return t;
   endfunction

endpackage

// File: rtl/btn_repeat_ctrl_if.sv
// Purpose : bundles the button/select levels, timebase strobe and the increment pulse outputs.
// Latency : n/a (wires only).
// Backpressure: none; pulses are fire-and-forget one-cycle strobes.
// Ports   : master = debouncer/timebase side (drives levels, consumes pulses),
//           slave  = btn_repeat_ctrl (consumes levels, drives pulses and status).
interface btn_repeat_ctrl_if;

   logic tick_en_pi;
   logic btn_min_pi;
   logic btn_hour_pi;
   logic sel_alarm0_pi;
   logic sel_alarm1_pi;
   logic clk_inc_min_po;
   logic clk_inc_hour_po;
   logic al0_inc_min_po;
   logic al0_inc_hour_po;
   logic al1_inc_min_po;
   logic al1_inc_hour_po;
   logic active_po;
   logic fast_po;

   modport master (
      output tick_en_pi, btn_min_pi, btn_hour_pi, sel_alarm0_pi, sel_alarm1_pi,
      input  clk_inc_min_po, clk_inc_hour_po, al0_inc_min_po, al0_inc_hour_po,
             al1_inc_min_po, al1_inc_hour_po, active_po, fast_po
   );

   modport slave (
      input  tick_en_pi, btn_min_pi, btn_hour_pi, sel_alarm0_pi, sel_alarm1_pi,
      output clk_inc_min_po, clk_inc_hour_po, al0_inc_min_po, al0_inc_hour_po,
             al1_inc_min_po, al1_inc_hour_po, active_po, fast_po
   );

endinterface

// File: rtl/repeat_tick_counter.sv
// Purpose : tick counter plus repeat-pulse counter; flags expiry of the currently selected period.
// Latency : expire_po/fast_nxt_po are combinational from the registered counts and inputs.
// Backpressure: none; clr_pi overrides adv_pi.
// Ports   : clk_pi/rst_n_pi clock and sync active-low reset; clr_pi zeroes both counts;
//           adv_pi is the tick strobe; hold_mode_pi selects the HOLD period (else repeat period);
//           expire_po = this tick ends the period; fast_nxt_po = repeat count will be saturated.
module repeat_tick_counter #(
   parameter int HOLD_TICKS   = 50,
   parameter int REPEAT_TICKS = 20,
   parameter int FAST_AFTER   = 8,
   parameter int FAST_TICKS   = 5,
   parameter int CNT_W        = 8
) (
   input  logic clk_pi,
   input  logic rst_n_pi,
   input  logic clr_pi,
   input  logic adv_pi,
   input  logic hold_mode_pi,
   output logic expire_po,
   output logic fast_nxt_po
);

   localparam logic [CNT_W-1:0] HOLD_M1   = CNT_W'(HOLD_TICKS - 1);
   localparam logic [CNT_W-1:0] REPEAT_M1 = CNT_W'(REPEAT_TICKS - 1);
   localparam logic [CNT_W-1:0] FAST_M1   = CNT_W'(FAST_TICKS - 1);
   localparam logic [CNT_W-1:0] FAST_SAT  = CNT_W'(FAST_AFTER);

   logic [CNT_W-1:0] tick_q, tick_d;
   logic [CNT_W-1:0] rep_q, rep_d;
   logic [CNT_W-1:0] period_m1;
   logic             at_end;

   always_comb begin
      if (hold_mode_pi)          period_m1 = HOLD_M1;
      else if (rep_q < FAST_SAT) period_m1 = REPEAT_M1;
      else                       period_m1 = FAST_M1;

      at_end    = (tick_q == period_m1);
      expire_po = adv_pi & at_end;

      tick_d = tick_q;
      rep_d  = rep_q;
      if (clr_pi) begin
         tick_d = '0;
         rep_d  = '0;
      end else if (adv_pi) begin
         if (at_end) begin
            tick_d = '0;
            // the HOLD expiry pulse is not a repeat; only REPEAT pulses advance the rate count
            if (!hold_mode_pi && (rep_q < FAST_SAT)) rep_d = rep_q + 1'b1;
         end else begin
            tick_d = tick_q + 1'b1;
         end
      end

      fast_nxt_po = (rep_d == FAST_SAT);
   end

   always_ff @(posedge clk_pi) begin
      if (!rst_n_pi) begin
         tick_q <= '0;
         rep_q  <= '0;
      end else begin
         tick_q <= tick_d;
         rep_q  <= rep_d;
      end
   end

endmodule

// File: rtl/btn_repeat_ctrl.sv
// Purpose : turns debounced minute/hour button levels into one-cycle increment pulses with auto-repeat,
//           routed to the clock or one alarm latched at press time.
// Latency : press seen at cycle N -> pulse at N+1; all outputs registered.
// Backpressure: none; at most one pulse output high per cycle.
// Ports   : clk_pi, rst_n_pi (sync, active-low); bus = btn_repeat_ctrl_if.slave
//           (tick_en/button/select levels in, six increment pulses plus active/fast status out).
module btn_repeat_ctrl
   import clock_pkg::*;
#(
   parameter int HOLD_TICKS   = 50,
   parameter int REPEAT_TICKS = 20,
   parameter int FAST_AFTER   = 8,
   parameter int FAST_TICKS   = 5,
   parameter int CNT_W        = 8
) (
   input  logic             clk_pi,
   input  logic             rst_n_pi,
   btn_repeat_ctrl_if.slave bus
);

   state_t     state_q, state_d;
   target_t    tgt_q, tgt_cur, pulse_tgt;
   owner_t     own_q, own_cur, pulse_own;
   logic [1:0] sel_q, sel_cur;

   logic btn_min_q, btn_hour_q;
   logic seen_low_min_q, seen_low_hour_q;
   logic press_min, press_hour, press_any;
   logic busy, owner_lvl, release_btn, sel_chg, leave;
   logic expire, fast_nxt, cnt_clr;

   logic       pulse;
   logic [5:0] inc_d, inc_q;   // {al1 hour, al1 min, al0 hour, al0 min, clk hour, clk min}
   logic       active_d, active_q, fast_d, fast_q;

   // A press needs the level to have been seen low since reset, so a button
   // still held through reset must be released and pressed again.
   assign press_min  = bus.btn_min_pi  & ~btn_min_q  & seen_low_min_q;
   assign press_hour = bus.btn_hour_pi & ~btn_hour_q & seen_low_hour_q;
   assign press_any  = press_min | press_hour;

   assign sel_cur = {bus.sel_alarm1_pi, bus.sel_alarm0_pi};
   assign tgt_cur = sel_to_target(bus.sel_alarm0_pi, bus.sel_alarm1_pi);
   assign own_cur = press_min ? OWN_MIN : OWN_HOUR;   // minute wins a same-cycle double press

   assign busy        = (state_q == HOLD) || (state_q == REPEAT);
   assign owner_lvl   = (own_q == OWN_MIN) ? bus.btn_min_pi : bus.btn_hour_pi;
   assign release_btn = busy & ~owner_lvl;
   assign sel_chg     = busy & (sel_cur != sel_q);
   assign leave       = release_btn | sel_chg;

   // counters run only while holding; any exit clears them so a release can never fire a pulse
   assign cnt_clr = !busy || leave;

   repeat_tick_counter #(
      .HOLD_TICKS  (HOLD_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS),
      .FAST_AFTER  (FAST_AFTER),
      .FAST_TICKS  (FAST_TICKS),
      .CNT_W       (CNT_W)
   ) u_cnt (
      .clk_pi      (clk_pi),
      .rst_n_pi    (rst_n_pi),
      .clr_pi      (cnt_clr),
      .adv_pi      (bus.tick_en_pi),
      .hold_mode_pi(state_q == HOLD),
      .expire_po   (expire),
      .fast_nxt_po (fast_nxt)
   );

   // state register plus press-time latches and edge-detect history
   always_ff @(posedge clk_pi) begin
      if (!rst_n_pi) begin
         state_q         <= IDLE;
         tgt_q           <= TGT_CLK;
         own_q           <= OWN_MIN;
         sel_q           <= 2'b00;
         btn_min_q       <= 1'b0;
         btn_hour_q      <= 1'b0;
         seen_low_min_q  <= 1'b0;
         seen_low_hour_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         btn_min_q       <= bus.btn_min_pi;
         btn_hour_q      <= bus.btn_hour_pi;
         seen_low_min_q  <= seen_low_min_q  | ~bus.btn_min_pi;
         seen_low_hour_q <= seen_low_hour_q | ~bus.btn_hour_pi;
         if ((state_q == IDLE) && press_any) begin
            tgt_q <= tgt_cur;
            own_q <= own_cur;
            sel_q <= sel_cur;
         end
      end
   end

   // next-state logic; release outranks select change and tick expiry
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (press_any) state_d = HOLD;
         HOLD: begin
            if (release_btn)  state_d = IDLE;
            else if (sel_chg) state_d = LOCKOUT;
            else if (expire)  state_d = REPEAT;
         end
         REPEAT: begin
            if (release_btn)  state_d = IDLE;
            else if (sel_chg) state_d = LOCKOUT;
         end
         LOCKOUT: if (!bus.btn_min_pi && !bus.btn_hour_pi) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // output decode
   always_comb begin
      pulse     = ((state_q == IDLE) && press_any) || (busy && !leave && expire);
      pulse_tgt = (state_q == IDLE) ? tgt_cur : tgt_q;
      pulse_own = (state_q == IDLE) ? own_cur : own_q;

      inc_d = 6'b000000;
      if (pulse) begin
         case (pulse_tgt)
            TGT_AL0: begin
               inc_d[2] = (pulse_own == OWN_MIN);
               inc_d[3] = (pulse_own == OWN_HOUR);
            end
            TGT_AL1: begin
               inc_d[4] = (pulse_own == OWN_MIN);
               inc_d[5] = (pulse_own == OWN_HOUR);
            end
            default: begin
               inc_d[0] = (pulse_own == OWN_MIN);
               inc_d[1] = (pulse_own == OWN_HOUR);
            end
         endcase
      end

      active_d = (state_d == HOLD) || (state_d == REPEAT);
      fast_d   = (state_d == REPEAT) && fast_nxt;
   end

   always_ff @(posedge clk_pi) begin
      if (!rst_n_pi) begin
         inc_q    <= 6'b000000;
         active_q <= 1'b0;
         fast_q   <= 1'b0;
      end else begin
         inc_q    <= inc_d;
         active_q <= active_d;
         fast_q   <= fast_d;
      end
   end

   assign bus.clk_inc_min_po  = inc_q[0];
   assign bus.clk_inc_hour_po = inc_q[1];
   assign bus.al0_inc_min_po  = inc_q[2];
   assign bus.al0_inc_hour_po = inc_q[3];
   assign bus.al1_inc_min_po  = inc_q[4];
   assign bus.al1_inc_hour_po = inc_q[5];
   assign bus.active_po       = active_q;
   assign bus.fast_po         = fast_q;

endmodule

// File: tb/tb_btn_repeat_ctrl.sv
// Purpose : directed bench for btn_repeat_ctrl with small periods; expected traces computed by hand.
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
// Trace byte per edge: {fast, active, al1h, al1m, al0h, al0m, clkh, clkm}.
module tb_btn_repeat_ctrl;

   logic clk_pi = 1'b0;
   logic rst_n_pi;

   btn_repeat_ctrl_if bif();

   btn_repeat_ctrl #(
      .HOLD_TICKS  (4),
      .REPEAT_TICKS(2),
      .FAST_AFTER  (2),
      .FAST_TICKS  (1),
      .CNT_W       (8)
   ) dut (
      .clk_pi  (clk_pi),
      .rst_n_pi(rst_n_pi),
      .bus     (bif.slave)
   );

   always #5 clk_pi = ~clk_pi;

   logic [7:0] trace [0:79];
   int tcnt;
   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // one clock edge; tick strobe lands on every 4th edge of the current test
   task automatic step();
      bif.tick_en_pi = (tcnt % 4 == 3);
      @(posedge clk_pi);
      #1;
      if (tcnt < 80)
         trace[tcnt] = {bif.fast_po, bif.active_po, bif.al1_inc_hour_po, bif.al1_inc_min_po,
                        bif.al0_inc_hour_po, bif.al0_inc_min_po, bif.clk_inc_hour_po, bif.clk_inc_min_po};
      tcnt++;
   endtask

   function automatic int cnt(input int lo, input int hi, input logic [7:0] mask);
      int n = 0;
      for (int i = lo; i <= hi; i++) if ((trace[i] & mask) != 8'h00) n++;
      return n;
   endfunction

   initial begin
      rst_n_pi          = 1'b0;
      bif.tick_en_pi    = 1'b0;
      bif.btn_min_pi    = 1'b0;
      bif.btn_hour_pi   = 1'b0;
      bif.sel_alarm0_pi = 1'b0;
      bif.sel_alarm1_pi = 1'b0;

      // reset state
      tcnt = 0;
      step(); step();
      chk("reset_outputs", 32'(trace[1]), 32'h00);
      rst_n_pi = 1'b1;
      tcnt = 0;
      step(); step();
      chk("idle_outputs", 32'(trace[1]), 32'h00);

      // short press: one clock-minute pulse, active until release
      tcnt = 0;
      for (int i = 0; i < 16; i++) begin
         bif.btn_min_pi = (i >= 2 && i < 12);
         step();
      end
      chk("short_pre",     32'(trace[1]),  32'h00);
      chk("short_pulse",   32'(trace[2]),  32'h41);
      chk("short_hold",    32'(trace[3]),  32'h40);
      chk("short_late",    32'(trace[11]), 32'h40);
      chk("short_release", 32'(trace[12]), 32'h00);
      chk("short_count",   32'(cnt(0, 15, 8'h3F)), 32'd1);

      // long hour hold: press, +4 ticks, 2 slow repeats, then every tick with fast set
      tcnt = 0;
      for (int i = 0; i < 63; i++) begin
         bif.btn_hour_pi = (i < 60);
         step();
      end
      chk("long_press",    32'(trace[0]),  32'h42);
      chk("long_prehold",  32'(trace[14]), 32'h40);
      chk("long_hold_exp", 32'(trace[15]), 32'h42);
      chk("long_rep1",     32'(trace[23]), 32'h42);
      chk("long_gap",      32'(trace[27]), 32'h40);
      chk("long_slowend",  32'(trace[30]), 32'h40);
      chk("long_fast_on",  32'(trace[31]), 32'hC2);
      chk("long_fast1",    32'(trace[35]), 32'hC2);
      chk("long_fast_gap", 32'(trace[36]), 32'hC0);
      chk("long_last",     32'(trace[59]), 32'hC2);
      chk("long_release",  32'(trace[60]), 32'h00);
      chk("long_count",    32'(cnt(0, 62, 8'h02)), 32'd11);
      chk("long_other",    32'(cnt(0, 62, 8'h3D)), 32'd0);

      // target priority, select change -> lockout, exit only after both buttons low
      tcnt = 0;
      for (int i = 0; i < 26; i++) begin
         bif.sel_alarm0_pi = 1'b1;
         bif.sel_alarm1_pi = (i < 5);
         bif.btn_min_pi    = (i < 20) || (i >= 22 && i < 24);
         bif.btn_hour_pi   = (i >= 10 && i < 12);
         step();
      end
      chk("tgt_al1_pulse", 32'(trace[0]),  32'h50);
      chk("tgt_hold",      32'(trace[4]),  32'h40);
      chk("tgt_lockout",   32'(trace[5]),  32'h00);
      chk("lock_silent",   32'(cnt(5, 21, 8'hFF)), 32'd0);
      chk("tgt_al0_pulse", 32'(trace[22]), 32'h44);
      chk("tgt_al0_hold",  32'(trace[23]), 32'h40);
      chk("tgt_al0_rel",   32'(trace[24]), 32'h00);
      bif.sel_alarm0_pi = 1'b0;
      bif.sel_alarm1_pi = 1'b0;

      // simultaneous press: minute owns; hour re-press while held is ignored
      tcnt = 0;
      for (int i = 0; i < 12; i++) begin
         bif.btn_min_pi  = (i < 10);
         bif.btn_hour_pi = (i < 2) || (i >= 4 && i < 10);
         step();
      end
      chk("simul_pulse",   32'(trace[0]),  32'h41);
      chk("simul_repress", 32'(trace[4]),  32'h40);
      chk("simul_no_hour", 32'(cnt(0, 11, 8'h02)), 32'd0);
      chk("simul_quiet",   32'(cnt(1, 11, 8'h3F)), 32'd0);
      chk("simul_release", 32'(trace[10]), 32'h00);

      // release on the same edge a repeat tick would fire
      tcnt = 0;
      for (int i = 0; i < 26; i++) begin
         bif.btn_min_pi = (i < 23);
         step();
      end
      chk("relexp_holdexp", 32'(trace[15]), 32'h41);
      chk("relexp_before",  32'(trace[22]), 32'h40);
      chk("relexp_edge",    32'(trace[23]), 32'h00);
      chk("relexp_count",   32'(cnt(0, 25, 8'h01)), 32'd2);

      // reset mid-REPEAT with button held: silent until a fresh edge
      tcnt = 0;
      for (int i = 0; i < 37; i++) begin
         bif.btn_hour_pi = (i < 31) || (i >= 33 && i < 35);
         rst_n_pi        = (i != 20);
         step();
      end
      chk("rst_rep_before", 32'(trace[19]), 32'h40);
      chk("rst_rep_zero",   32'(trace[20]), 32'h00);
      chk("rst_rep_held",   32'(cnt(21, 32, 8'hFF)), 32'd0);
      chk("rst_rep_fresh",  32'(trace[33]), 32'h42);
      chk("rst_rep_rel",    32'(trace[35]), 32'h00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/btn_repeat_ctrl.md
Name: btn_repeat_ctrl

Overview:
- Sits between the button debouncers and the clock/alarm state machines.
- Converts debounced minute/hour button levels into one-cycle increment pulses: one pulse on press, then auto-repeat while held, accelerating after a set number of repeats.
- Routes pulses to exactly one target (clock, alarm0 or alarm1), latched at press time. The top level no longer gates increment pulses with select buttons.

Parameters:
- HOLD_TICKS, 50, tick strobes a button must stay held after the press pulse before auto-repeat starts.
- REPEAT_TICKS, 20, tick strobes between slow repeat pulses.
- FAST_AFTER, 8, number of slow repeat pulses after which fast repeat is used.
- FAST_TICKS, 5, tick strobes between fast repeat pulses.
- CNT_W, 8, width of the tick counter; must hold max(HOLD_TICKS, REPEAT_TICKS, FAST_TICKS).

Ports:
- clk_pi  in  1  system clock
- rst_n_pi  in  1  synchronous reset, active-low
- tick_en_pi  in  1  one-cycle timebase strobe (nominally 100 Hz from a clkdiv)
- btn_min_pi  in  1  debounced minute-button level, 1 = held
- btn_hour_pi  in  1  debounced hour-button level, 1 = held
- sel_alarm0_pi  in  1  alarm0 select level
- sel_alarm1_pi  in  1  alarm1 select level
- clk_inc_min_po  out  1  clock minute increment pulse
- clk_inc_hour_po  out  1  clock hour increment pulse
- al0_inc_min_po  out  1  alarm0 minute increment pulse
- al0_inc_hour_po  out  1  alarm0 hour increment pulse
- al1_inc_min_po  out  1  alarm1 minute increment pulse
- al1_inc_hour_po  out  1  alarm1 hour increment pulse
- active_po  out  1  1 while in HOLD or REPEAT
- fast_po  out  1  1 while repeating at the fast rate

Behaviour:
- Reset (rst_n_pi=0 at posedge): state=IDLE; counters=0; previous-level registers=0; all outputs 0. Reset mid-hold aborts with no pulse.
- Edge detect: a press is btn level 1 this cycle and 0 in the registered previous value.
- All outputs are registered. A press seen at cycle N gives its pulse at N+1. Every pulse is exactly one cycle wide, and at most one of the six pulse outputs is high in any cycle.
- Target selection, latched on press: sel_alarm1_pi → AL1; else sel_alarm0_pi → AL0; else CLK. Owner button is latched too; if both buttons rise in the same cycle, minute wins.
- IDLE:
  - press → emit one pulse to (target, owner); tick_cnt=0; go HOLD.
  - A rising edge of the other button while not IDLE is ignored.
- HOLD:
  - Each tick_en_pi increments tick_cnt.
  - When a tick arrives with tick_cnt==HOLD_TICKS-1: emit pulse, tick_cnt=0, rep_cnt=0, go REPEAT.
- REPEAT:
  - Period P = (rep_cnt<FAST_AFTER) ? REPEAT_TICKS : FAST_TICKS.
  - A tick with tick_cnt==P-1 emits a pulse and clears tick_cnt.
  - rep_cnt increments per pulse and saturates at FAST_AFTER.
  - fast_po = (rep_cnt==FAST_AFTER).
- Release: owner button level 0 in HOLD or REPEAT → IDLE next cycle, no pulse that cycle, counters cleared. Same-cycle release and tick-expiry: release wins, no pulse.
- Select change: any change of the select encoding while in HOLD or REPEAT → LOCKOUT, no pulse.
- LOCKOUT: no pulses; go to IDLE only when both button levels are 0. A button still held on entry to IDLE does not count as a press; a new 0→1 edge is required.
- active_po = state∈{HOLD,REPEAT}. active_po and fast_po are both 0 in IDLE and LOCKOUT.
- tick_en_pi is ignored in IDLE and LOCKOUT. Counters never wrap: the compare fires before overflow given the CNT_W rule.

Decomposition:
- Shared package clock_pkg:
  - state enum {IDLE, HOLD, REPEAT, LOCKOUT}
  - target enum {TGT_CLK, TGT_AL0, TGT_AL1}
  - owner enum {OWN_MIN, OWN_HOUR}
- One sub-module, repeat_tick_counter: tick_cnt plus rep_cnt with clear/advance inputs and an expire output for a selected period. The FSM and output decode stay in btn_repeat_ctrl.

Test Plan (HOLD_TICKS=4, REPEAT_TICKS=2, FAST_AFTER=2, FAST_TICKS=1, tick_en every 4 cycles):
- Short press: btn_min 0→1 at cycle 10, released at cycle 20 → clk_inc_min_po high only at cycle 11; active_po returns to 0 at cycle 21.
- Long hold with no selects: btn_hour held for 60 cycles → clk_inc_hour_po pulses at press+1, then after 4 ticks, then every 2 ticks ×2, then every tick; fast_po rises with the 3rd repeat pulse.
- Target latch and priority: sel_alarm0=1 and sel_alarm1=1 at press of btn_min → only al1_inc_min_po pulses. Dropping sel_alarm1 mid-hold → LOCKOUT, no further pulses; IDLE only after btn_min=0.
- Simultaneous press: both buttons rise in the same cycle → al/clk minute pulse only; btn_hour release and re-press while minute is held → no hour pulse.
- Release vs expiry: release in the same cycle a REPEAT tick would fire → no pulse, state IDLE.
- Reset mid-REPEAT: rst_n_pi=0 for 1 cycle → all outputs 0 next cycle. With the button still held after reset, no pulse until a fresh 0→1 edge.
